// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the LC-3 memory responder.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int WORD_W = 16;
endpackage

// File: rtl/sync_ram.sv
// sync_ram: single-port word RAM with synchronous write and registered read.
module sync_ram
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    din,
  output logic [WORD_W-1:0]    q
);
  logic [WORD_W-1:0] mem [2**ADDR_BITS];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    q <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: MAR/MDR memory responder with wait states, word RAM and switch/hex I/O port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset_ah,
  input  logic              MEM_EN,
  input  logic              WE,
  input  logic [WORD_W-1:0] ADDR,
  input  logic [WORD_W-1:0] DATA_W,
  input  logic [WORD_W-1:0] Switches,
  output logic [WORD_W-1:0] Data_to_CPU,
  output logic              R,
  output logic              Busy,
  output logic [WORD_W-1:0] HEX_Data
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam bit WS0 = (WAIT_STATES == 0);
  state_t state, nxt;
  logic [3:0] cnt;
  logic [WORD_W-1:0] addr_q, din_q, rdata_q, hex_q, sw_m, sw_s, ram_q, cur_addr, cur_din, rd_val;
  logic we_q, cur_we, accept, enter_done, wr, ram_hit, io_hit, rd_cap;
  // In IDLE the live request drives the RAM so a zero-wait access still lands in time.
  assign accept     = (state == IDLE) && MEM_EN;
  assign cur_addr   = (state == IDLE) ? ADDR : addr_q;
  assign cur_din    = (state == IDLE) ? DATA_W : din_q;
  assign cur_we     = (state == IDLE) ? WE : we_q;
  assign enter_done = (accept && WS0) || ((state == WAIT) && (cnt == 4'd0));
  assign ram_hit    = (cur_addr >> ADDR_BITS) == '0;
  assign io_hit     = cur_addr == IO_ADDR;
  assign wr         = enter_done && cur_we && !Reset_ah;
  assign rd_val     = (addr_q == IO_ADDR) ? sw_s : ((addr_q >> ADDR_BITS) == '0) ? ram_q : '0;
  assign rd_cap     = WS0 ? ((state == DONE) && !we_q) : (enter_done && !we_q);
  assign Data_to_CPU = (WS0 && (state == DONE) && !we_q) ? rd_val : rdata_q;
  assign R          = state == DONE;
  assign Busy       = state != IDLE;
  assign HEX_Data   = hex_q;
  sync_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk (Clk),
    .we  (wr && ram_hit),
    .addr(cur_addr[ADDR_BITS-1:0]),
    .din (cur_din),
    .q   (ram_q)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = MEM_EN ? (WS0 ? DONE : WAIT) : IDLE;
      WAIT:    nxt = (cnt == 4'd0) ? DONE : WAIT;
      DONE:    nxt = HOLD;
      default: nxt = MEM_EN ? HOLD : IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      hex_q   <= '0;
      sw_m    <= '0;
      sw_s    <= '0;
    end else begin
      state <= nxt;
      cnt   <= accept ? WS : ((state == WAIT) && (cnt != 4'd0)) ? cnt - 4'd1 : cnt;
      if (accept) begin
        addr_q <= ADDR;
        din_q  <= DATA_W;
        we_q   <= WE;
      end
      if (wr && io_hit) hex_q <= cur_din;
      if (rd_cap) rdata_q <= rd_val;
      sw_m <= Switches;
      sw_s <= sw_m;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder (ADDR_BITS=8, WAIT_STATES=2).
module tb_mem_responder;
  logic        Clk = 0, Reset_ah = 1, MEM_EN = 0, WE = 0, R, Busy;
  logic [15:0] ADDR = 0, DATA_W = 0, Switches = 0, Data_to_CPU, HEX_Data;
  int checks = 0, errors = 0;
  mem_responder #(.ADDR_BITS(8), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset_ah(Reset_ah), .MEM_EN(MEM_EN), .WE(WE), .ADDR(ADDR),
    .DATA_W(DATA_W), .Switches(Switches), .Data_to_CPU(Data_to_CPU), .R(R),
    .Busy(Busy), .HEX_Data(HEX_Data)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // One full request; inputs are scrambled right after acceptance to prove they were latched.
  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d, input string tag);
    int n;
    logic seen;
    @(negedge Clk);
    MEM_EN = 1; WE = w; ADDR = a; DATA_W = d;
    @(posedge Clk);
    n = 0; seen = 0;
    while (n < 50 && !seen) begin
      @(negedge Clk);
      if (n == 0) begin WE = ~w; ADDR = ~a; DATA_W = ~d; end
      if (R) seen = 1;
      else begin @(posedge Clk); n++; end
    end
    chk({tag, "_lat"}, seen ? 16'(n) : 16'hFFFF, 16'd3);
    MEM_EN = 0;
    @(negedge Clk);
    chk({tag, "_rpulse"}, {15'd0, R}, 16'd0);
    @(negedge Clk);
  endtask
  initial begin
    int pulses;
    logic busy_all, saw_r;
    repeat (2) @(negedge Clk);
    chk("rst_r", {15'd0, R}, 16'd0);
    chk("rst_busy", {15'd0, Busy}, 16'd0);
    chk("rst_data", Data_to_CPU, 16'h0000);
    chk("rst_hex", HEX_Data, 16'h0000);
    Reset_ah = 0;
    req(1, 16'h0000, 16'h0ABC, "pre0");
    req(1, 16'h00FF, 16'h0FF0, "preff");
    req(1, 16'h0005, 16'h1234, "t1w");
    req(0, 16'h0005, 16'h0000, "t1r");
    chk("t1_data", Data_to_CPU, 16'h1234);
    req(1, 16'hFFFF, 16'hBEEF, "t2w");
    chk("t2_hex", HEX_Data, 16'hBEEF);
    req(0, 16'h00FF, 16'h0000, "t2r_ff");
    chk("t2_ff", Data_to_CPU, 16'h0FF0);
    req(0, 16'h0000, 16'h0000, "t2r_0");
    chk("t2_0", Data_to_CPU, 16'h0ABC);
    Switches = 16'h00A5;
    repeat (3) @(negedge Clk);
    req(0, 16'hFFFF, 16'h0000, "t3r");
    chk("t3_sw", Data_to_CPU, 16'h00A5);
    // held MEM_EN: one pulse only, Busy throughout
    @(negedge Clk);
    MEM_EN = 1; WE = 0; ADDR = 16'h0005;
    pulses = 0; busy_all = 1;
    repeat (20) begin
      @(negedge Clk);
      if (R) pulses++;
      busy_all &= Busy;
    end
    chk("t4_pulses", 16'(pulses), 16'd1);
    chk("t4_busy", {15'd0, busy_all}, 16'd1);
    chk("t4_data", Data_to_CPU, 16'h1234);
    MEM_EN = 0;
    @(negedge Clk);
    chk("t4_idle", {15'd0, Busy}, 16'd0);
    req(1, 16'h0010, 16'h1111, "t5w");
    @(negedge Clk);
    MEM_EN = 1; WE = 1; ADDR = 16'h0010; DATA_W = 16'h5555;
    saw_r = 0;
    @(negedge Clk);
    saw_r |= R;
    chk("t5_inwait", {15'd0, Busy}, 16'd1);
    Reset_ah = 1;
    @(negedge Clk);
    saw_r |= R;
    chk("t5_busy", {15'd0, Busy}, 16'd0);
    chk("t5_hex", HEX_Data, 16'h0000);
    Reset_ah = 0; MEM_EN = 0;
    repeat (3) begin @(negedge Clk); saw_r |= R; end
    chk("t5_nor", {15'd0, saw_r}, 16'd0);
    req(0, 16'h0010, 16'h0000, "t5r");
    chk("t5_data", Data_to_CPU, 16'h1111);
    req(1, 16'h0100, 16'h7777, "t6w");
    req(0, 16'h0100, 16'h0000, "t6r_oor");
    chk("t6_oor", Data_to_CPU, 16'h0000);
    req(0, 16'h0000, 16'h0000, "t6r_0");
    chk("t6_0", Data_to_CPU, 16'h0ABC);
    chk("t6_hex", HEX_Data, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
